// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: tick divider, paddles, ball physics, scoring FSM.
// Optional PONG_AI_EN makes P2 track the ball instead of following p2_up/p2_dn.
module pong_game_ctrl #(
  parameter int unsigned TICK_DIV  = 4,
  parameter int unsigned PADDLE_H  = 8,
  parameter int unsigned SERVE_DLY = 16,
  parameter int unsigned WIN_SCORE = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       p1_up,
  input  logic       p1_dn,
  input  logic       p2_up,
  input  logic       p2_dn,
  output logic [5:0] bx,
  output logic [5:0] by,
  output logic [5:0] p1y,
  output logic [5:0] p2y,
  output logic [2:0] sc1,
  output logic [2:0] sc2,
  output logic [2:0] state,
  output logic       frame_tick
);

  localparam int unsigned CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [5:0]  PC   = 6'((64 - PADDLE_H) / 2);
  localparam logic [6:0]  PMAX = 7'(64 - PADDLE_H);
  localparam logic [6:0]  PH   = 7'(PADDLE_H);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StServe    = 3'd1,
    StPlay     = 3'd2,
    StPoint    = 3'd3,
    StGameover = 3'd4
  } state_e;

  state_e        st_q, st_d;
  logic [CW-1:0] cnt_q;
  logic [15:0]   srv_q, srv_d;
  logic [5:0]    bx_q, bx_d, by_q, by_d, p1y_q, p1y_d, p2y_q, p2y_d;
  logic [2:0]    sc1_q, sc1_d, sc2_q, sc2_d;
  // Direction flags: 1 = moving toward row/column 0.
  logic          dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
  logic          loser_p1_q, loser_p1_d;
  logic          ft_q, tick;
  logic          p2_up_eff, p2_dn_eff, p1_hit, p2_hit;
  logic [5:0]    p1_new, p2_new;

  function automatic logic [5:0] move_paddle(input logic [5:0] py, input logic up,
                                             input logic dn);
    if (up && !dn && py != 6'd0) return py - 6'd1;
    if (dn && !up && {1'b0, py} < PMAX) return py + 6'd1;
    return py;
  endfunction

`ifdef PONG_AI_EN
  logic [6:0] p2_mid;
  logic       unused_p2_btn;
  assign p2_mid        = {1'b0, p2y_q} + 7'(PADDLE_H / 2);
  assign p2_up_eff     = {1'b0, by_q} < p2_mid;
  assign p2_dn_eff     = {1'b0, by_q} > p2_mid;
  assign unused_p2_btn = p2_up ^ p2_dn;
`else
  assign p2_up_eff = p2_up;
  assign p2_dn_eff = p2_dn;
`endif

  assign tick   = (cnt_q == CW'(TICK_DIV - 1));
  assign p1_new = move_paddle(p1y_q, p1_up, p1_dn);
  assign p2_new = move_paddle(p2y_q, p2_up_eff, p2_dn_eff);
  // Hit windows use the post-move paddle row against the pre-move ball row.
  assign p1_hit = ({1'b0, by_q} >= {1'b0, p1_new}) && ({1'b0, by_q} < {1'b0, p1_new} + PH);
  assign p2_hit = ({1'b0, by_q} >= {1'b0, p2_new}) && ({1'b0, by_q} < {1'b0, p2_new} + PH);

  always_comb begin
    st_d       = st_q;
    srv_d      = srv_q;
    bx_d       = bx_q;
    by_d       = by_q;
    p1y_d      = p1y_q;
    p2y_d      = p2y_q;
    sc1_d      = sc1_q;
    sc2_d      = sc2_q;
    dx_neg_d   = dx_neg_q;
    dy_neg_d   = dy_neg_q;
    loser_p1_d = loser_p1_q;
    unique case (st_q)
      StIdle: begin
        if (start) begin
          st_d  = StServe;
          srv_d = '0;
          sc1_d = '0;
          sc2_d = '0;
          bx_d  = 6'd32;
          by_d  = 6'd32;
          p1y_d = PC;
          p2y_d = PC;
        end
      end
      StServe: begin
        bx_d     = 6'd32;
        by_d     = 6'd32;
        dy_neg_d = 1'b0;
        dx_neg_d = loser_p1_q;
        if (tick) begin
          p1y_d = p1_new;
          p2y_d = p2_new;
          if (srv_q == 16'(SERVE_DLY - 1)) begin
            st_d  = StPlay;
            srv_d = '0;
          end else begin
            srv_d = srv_q + 16'd1;
          end
        end
      end
      StPlay: begin
        if (tick) begin
          p1y_d = p1_new;
          p2y_d = p2_new;
          if (by_q == 6'd0 && dy_neg_q) begin
            dy_neg_d = 1'b0;
            by_d     = 6'd1;
          end else if (by_q == 6'd63 && !dy_neg_q) begin
            dy_neg_d = 1'b1;
            by_d     = 6'd62;
          end else begin
            by_d = dy_neg_q ? by_q - 6'd1 : by_q + 6'd1;
          end
          if (bx_q == 6'd2 && dx_neg_q && p1_hit) begin
            dx_neg_d = 1'b0;
            bx_d     = 6'd3;
          end else if (bx_q == 6'd61 && !dx_neg_q && p2_hit) begin
            dx_neg_d = 1'b1;
            bx_d     = 6'd60;
          end else begin
            bx_d = dx_neg_q ? bx_q - 6'd1 : bx_q + 6'd1;
          end
          if (bx_d == 6'd0 || bx_d == 6'd63) st_d = StPoint;
        end
      end
      StPoint: begin
        // Ball parked at column 0 means P2 scored, column 63 means P1 scored.
        if (bx_q == 6'd0) begin
          sc2_d      = sc2_q + 3'd1;
          loser_p1_d = 1'b1;
        end else begin
          sc1_d      = sc1_q + 3'd1;
          loser_p1_d = 1'b0;
        end
        if (sc1_d == 3'(WIN_SCORE) || sc2_d == 3'(WIN_SCORE)) begin
          st_d = StGameover;
        end else begin
          st_d  = StServe;
          srv_d = '0;
          bx_d  = 6'd32;
          by_d  = 6'd32;
        end
      end
      StGameover: begin
        if (start) begin
          st_d       = StServe;
          srv_d      = '0;
          sc1_d      = '0;
          sc2_d      = '0;
          bx_d       = 6'd32;
          by_d       = 6'd32;
          p1y_d      = PC;
          p2y_d      = PC;
          loser_p1_d = 1'b0;
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= StIdle;
      cnt_q      <= '0;
      srv_q      <= '0;
      bx_q       <= 6'd32;
      by_q       <= 6'd32;
      p1y_q      <= PC;
      p2y_q      <= PC;
      sc1_q      <= '0;
      sc2_q      <= '0;
      dx_neg_q   <= 1'b0;
      dy_neg_q   <= 1'b0;
      loser_p1_q <= 1'b0;
      ft_q       <= 1'b0;
    end else begin
      st_q       <= st_d;
      cnt_q      <= tick ? '0 : cnt_q + CW'(1);
      srv_q      <= srv_d;
      bx_q       <= bx_d;
      by_q       <= by_d;
      p1y_q      <= p1y_d;
      p2y_q      <= p2y_d;
      sc1_q      <= sc1_d;
      sc2_q      <= sc2_d;
      dx_neg_q   <= dx_neg_d;
      dy_neg_q   <= dy_neg_d;
      loser_p1_q <= loser_p1_d;
      ft_q       <= tick;
    end
  end

  assign bx         = bx_q;
  assign by         = by_q;
  assign p1y        = p1y_q;
  assign p2y        = p2y_q;
  assign sc1        = sc1_q;
  assign sc2        = sc2_q;
  assign state      = st_q;
  assign frame_tick = ft_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Randomized scoreboard bench for pong_game_ctrl: a game-level model predicts the
// visible state on every frame_tick; a monitor compares whenever frame_tick fires.
module tb_pong_game_ctrl;

  localparam int TD   = 4;
  localparam int PH   = 8;
  localparam int SD   = 2;
  localparam int WS   = 3;
  localparam int PC   = (64 - PH) / 2;
  localparam int NCYC = 24000;

  logic       clk, rst, start, p1_up, p1_dn, p2_up, p2_dn;
  logic [5:0] bx, by, p1y, p2y;
  logic [2:0] sc1, sc2, state;
  logic       frame_tick;

  pong_game_ctrl #(
    .TICK_DIV (TD),
    .PADDLE_H (PH),
    .SERVE_DLY(SD),
    .WIN_SCORE(WS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .p1_up     (p1_up),
    .p1_dn     (p1_dn),
    .p2_up     (p2_up),
    .p2_dn     (p2_dn),
    .bx        (bx),
    .by        (by),
    .p1y       (p1y),
    .p2y       (p2y),
    .sc1       (sc1),
    .sc2       (sc2),
    .state     (state),
    .frame_tick(frame_tick)
  );

  typedef struct packed {
    logic [2:0] st;
    logic [5:0] bx, by, p1y, p2y;
    logic [2:0] sc1, sc2;
  } snap_t;

  snap_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    n_points = 0;
  int    n_gameover = 0;

  // Game-level reference model (directions as +1/-1, players as 1/2).
  int m_cnt, m_st, m_bx, m_by, m_dx, m_dy, m_p1, m_p2, m_s1, m_s2, m_srv, m_loser, m_scorer;
  bit m_ft;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int mv(input int py, input bit up, input bit dn);
    if (up && !dn) return (py > 0) ? py - 1 : py;
    if (dn && !up) return (py < 64 - PH) ? py + 1 : py;
    return py;
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s.st  = 3'(m_st);
    s.bx  = 6'(m_bx);
    s.by  = 6'(m_by);
    s.p1y = 6'(m_p1);
    s.p2y = 6'(m_p2);
    s.sc1 = 3'(m_s1);
    s.sc2 = 3'(m_s2);
    return s;
  endfunction

  task automatic enter_serve();
    m_st  = 1;
    m_srv = 0;
    m_bx  = 32;
    m_by  = 32;
    m_dy  = 1;
    m_dx  = (m_loser == 2) ? 1 : -1;
  endtask

  task automatic move_paddles(input bit u1, input bit d1, input bit u2, input bit d2);
    bit a_up, a_dn;
`ifdef PONG_AI_EN
    a_up = m_by < m_p2 + PH / 2;
    a_dn = m_by > m_p2 + PH / 2;
`else
    a_up = u2;
    a_dn = d2;
`endif
    m_p1 = mv(m_p1, u1, d1);
    m_p2 = mv(m_p2, a_up, a_dn);
  endtask

  task automatic model_edge(input bit r, input bit s, input bit u1, input bit d1,
                            input bit u2, input bit d2);
    bit tk;
    int ny, oby;
    if (r) begin
      m_cnt = 0; m_st = 0; m_bx = 32; m_by = 32; m_dx = 1; m_dy = 1;
      m_p1 = PC; m_p2 = PC; m_s1 = 0; m_s2 = 0; m_srv = 0; m_loser = 2; m_ft = 0;
      return;
    end
    tk    = (m_cnt == TD - 1);
    m_ft  = tk;
    m_cnt = (m_cnt + 1) % TD;
    case (m_st)
      0: if (s) begin
        m_s1 = 0; m_s2 = 0; m_p1 = PC; m_p2 = PC;
        enter_serve();
      end
      1: if (tk) begin
        move_paddles(u1, d1, u2, d2);
        m_srv++;
        if (m_srv == SD) m_st = 2;
      end
      2: if (tk) begin
        move_paddles(u1, d1, u2, d2);
        oby = m_by;
        ny  = m_by + m_dy;
        if (ny < 0) begin m_by = 1; m_dy = 1; end
        else if (ny > 63) begin m_by = 62; m_dy = -1; end
        else m_by = ny;
        if (m_dx < 0 && m_bx == 2 && oby >= m_p1 && oby < m_p1 + PH) begin
          m_dx = 1; m_bx = 3;
        end else if (m_dx > 0 && m_bx == 61 && oby >= m_p2 && oby < m_p2 + PH) begin
          m_dx = -1; m_bx = 60;
        end else begin
          m_bx += m_dx;
        end
        if (m_bx == 0) begin m_st = 3; m_scorer = 2; end
        if (m_bx == 63) begin m_st = 3; m_scorer = 1; end
      end
      3: begin
        n_points++;
        if (m_scorer == 2) begin m_s2++; m_loser = 1; end
        else begin m_s1++; m_loser = 2; end
        if (m_s1 == WS || m_s2 == WS) begin m_st = 4; n_gameover++; end
        else enter_serve();
      end
      4: if (s) begin
        m_s1 = 0; m_s2 = 0; m_p1 = PC; m_p2 = PC; m_loser = 2;
        enter_serve();
      end
      default: ;
    endcase
  endtask

  // Monitor: every frame_tick the DUT presents a frame; pop the prediction for it.
  initial begin
    snap_t g, e;
    forever begin
      @(negedge clk);
      if (frame_tick === 1'b1) begin
        checks++;
        g = {state, bx, by, p1y, p2y, sc1, sc2};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame_tick t=%0t got st=%0d bx=%0d by=%0d", $time,
                   state, bx, by);
        end else begin
          e = exp_q.pop_front();
          if (g !== e) begin
            errors++;
            $display({"FAIL frame t=%0t got st=%0d bx=%0d by=%0d p1y=%0d p2y=%0d sc=%0d/%0d",
                      " exp st=%0d bx=%0d by=%0d p1y=%0d p2y=%0d sc=%0d/%0d"},
                     $time, g.st, g.bx, g.by, g.p1y, g.p2y, g.sc1, g.sc2,
                     e.st, e.bx, e.by, e.p1y, e.p2y, e.sc1, e.sc2);
          end
        end
      end
    end
  end

  task automatic check_reset();
    snap_t g, e;
    g = {state, bx, by, p1y, p2y, sc1, sc2};
    e = model_snap();
    checks++;
    if (g !== e || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_values t=%0t got st=%0d bx=%0d by=%0d p1y=%0d ft=%0b exp st=%0d",
               $time, g.st, g.bx, g.by, g.p1y, frame_tick, e.st);
    end
  endtask

  initial begin
    int  m1, m2;
    bit  did_rst, r, s, u1, d1, u2, d2;
    rst = 1'b1; start = 1'b0;
    p1_up = 1'b0; p1_dn = 1'b0; p2_up = 1'b0; p2_dn = 1'b0;
    model_edge(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    did_rst = 1'b1;
    m1 = 0;
    m2 = 0;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      if (did_rst) check_reset();
      if (c % 160 == 0) begin
        m1 = $urandom_range(0, 4);
        m2 = $urandom_range(0, 4);
      end
      r  = (c < 2) || ($urandom_range(0, 3999) == 0);
      s  = ($urandom_range(0, 39) == 0);
      u1 = (m1 == 1) || (m1 == 3) || (m1 == 4 && $urandom_range(0, 1) == 1);
      d1 = (m1 == 2) || (m1 == 3) || (m1 == 4 && $urandom_range(0, 1) == 1);
      u2 = (m2 == 1) || (m2 == 3) || (m2 == 4 && $urandom_range(0, 1) == 1);
      d2 = (m2 == 2) || (m2 == 3) || (m2 == 4 && $urandom_range(0, 1) == 1);
      rst = r; start = s; p1_up = u1; p1_dn = d1; p2_up = u2; p2_dn = d2;
      did_rst = r;
      model_edge(r, s, u1, d1, u2, d2);
      if (m_ft) exp_q.push_back(model_snap());
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_frame_ticks got %0d pending exp 0", exp_q.size());
    end
    $display("points=%0d gameovers=%0d", n_points, n_gameover);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
